// File: rtl/tag_ex_stage.sv
// Single-entry tag execute stage: derives the result tag from the operand tags,
// holds it for writeback, and traps tag-check violations until they are acknowledged.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | no instruction held; ready to capture
// S_FULL  | result tag held; wb_valid_o asserted until writeback accepts
// S_EXC   | violation pending; exc_o asserted, rd never written
module tag_ex_stage #(
  parameter int ALU_MODE_WIDTH = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  output logic                      ex_ready_o,
  input  logic [ALU_MODE_WIDTH-1:0] alu_operator_i_mode,
  input  logic                      rs1_tag_i,
  input  logic                      rs2_tag_i,
  input  logic                      rd_old_tag_i,
  input  logic [4:0]                rd_addr_i,
  input  logic                      rd_we_i,
  input  logic                      check_i,
  input  logic                      check_en_i,
  input  logic                      flush_i,
  input  logic                      wb_ready_i,
  output logic                      wb_valid_o,
  output logic                      wb_tag_o,
  output logic [4:0]                wb_addr_o,
  output logic                      wb_we_o,
  output logic                      exc_o,
  input  logic                      exc_ack_i,
  output logic [CNT_WIDTH-1:0]      viol_cnt_o
);

  localparam logic [ALU_MODE_WIDTH-1:0] MODE_OLD = ALU_MODE_WIDTH'(0);
  localparam logic [ALU_MODE_WIDTH-1:0] MODE_AND = ALU_MODE_WIDTH'(1);
  localparam logic [ALU_MODE_WIDTH-1:0] MODE_OR  = ALU_MODE_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_EXC   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 result_tag;
  logic                 violation;
  logic                 capture;
  logic                 enter_exc;
  logic                 wb_tag_q;
  logic [4:0]           wb_addr_q;
  logic                 wb_we_q;
  logic [CNT_WIDTH-1:0] viol_cnt_q;

  // CLEAR and any unencoded wider mode value both produce an untainted result
  always_comb begin
    result_tag = 1'b0;
    case (alu_operator_i_mode)
      MODE_OLD: result_tag = rd_old_tag_i;
      MODE_AND: result_tag = rs1_tag_i & rs2_tag_i;
      MODE_OR:  result_tag = rs1_tag_i | rs2_tag_i;
      default:  result_tag = 1'b0;
    endcase
  end

  assign ex_ready_o = (state_q == S_EMPTY) || ((state_q == S_FULL) && wb_ready_i);
  assign capture    = id_valid_i && ex_ready_o && !flush_i;
  assign violation  = check_i && check_en_i && result_tag;
  assign enter_exc  = capture && violation;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (capture) state_d = violation ? S_EXC : S_FULL;
      end
      S_FULL: begin
        if (flush_i)         state_d = S_EMPTY;
        else if (capture)    state_d = violation ? S_EXC : S_FULL;
        else if (wb_ready_i) state_d = S_EMPTY;
      end
      S_EXC: begin
        if (exc_ack_i) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      wb_tag_q   <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_we_q    <= 1'b0;
      viol_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        wb_tag_q  <= result_tag;
        wb_addr_q <= rd_addr_i;
        // a trapped instruction must never look like a pending register write
        wb_we_q   <= rd_we_i && !violation;
      end
      if (enter_exc && (viol_cnt_q != CNT_MAX)) viol_cnt_q <= viol_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign wb_valid_o = (state_q == S_FULL);
  assign exc_o      = (state_q == S_EXC);
  assign wb_tag_o   = wb_tag_q;
  assign wb_addr_o  = wb_addr_q;
  assign wb_we_o    = wb_we_q;
  assign viol_cnt_o = viol_cnt_q;

endmodule
